// File: rtl/img_row_streamer.sv
// rtl/img_row_streamer.sv - single-image pixel buffer streaming rows to the cnn on interrupt
// Optional feature: STREAM_INTR_QUEUE_EN queues interrupt edges seen while a row is streaming.
module img_row_streamer #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int PRIME_ROWS = 4,
    parameter int DW         = 8,
    parameter int FLIP_ROWS  = 1
) (
    input  logic          axi_clk,
    input  logic          axi_rst_n,
    input  logic          i_ld_valid,
    input  logic [DW-1:0] i_ld_data,
    output logic          o_ld_done,
    input  logic          i_start,
    input  logic          i_intr,
    output logic          o_data_valid,
    output logic [DW-1:0] o_data,
    output logic [4:0]    o_row_idx,
    output logic          o_busy,
    output logic          o_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);

    typedef enum logic [2:0] {
        S_LOAD,
        S_READY,
        S_PRIME,
        S_WAIT_INTR,
        S_ROW
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [0:NPIX-1];
    logic [4:0]    ld_row;
    logic [4:0]    ld_col;
    logic [4:0]    ld_row_st;
    logic [4:0]    rd_row;
    logic [4:0]    rd_col;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic          ld_last;
    logic          emit;
    logic          intr_q;
    logic          intr_edge;
`ifdef STREAM_INTR_QUEUE_EN
    logic [4:0]    pending;
`endif

    // Address generation and the per-cycle "emit one pixel" decision
    always_comb begin
        intr_edge = i_intr & ~intr_q;
        wr_en     = i_ld_valid && (state == S_LOAD || state == S_READY);
        ld_last   = (ld_row == 5'(IMG_H - 1)) && (ld_col == 5'(IMG_W - 1));
        ld_row_st = (FLIP_ROWS != 0) ? (5'(IMG_H - 1) - ld_row) : ld_row;
        wr_addr   = AW'(ld_row_st) * AW'(IMG_W) + AW'(ld_col);
        rd_addr   = AW'(rd_row) * AW'(IMG_W) + AW'(rd_col);
        emit      = 1'b0;
        case (state)
            S_READY:     emit = i_start && !i_ld_valid;
            S_PRIME:     emit = !((rd_col == 5'd0) && (rd_row == 5'(PRIME_ROWS)));
`ifdef STREAM_INTR_QUEUE_EN
            S_WAIT_INTR: emit = intr_edge || (pending != 5'd0);
`else
            S_WAIT_INTR: emit = intr_edge;
`endif
            S_ROW:       emit = (rd_col != 5'd0);
            default:     emit = 1'b0;
        endcase
    end

    // Pixel buffer write port; contents are not reset
    always_ff @(posedge axi_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= i_ld_data;
        end
    end

    // Registered pixel read, aligned with o_data_valid and held when idle
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            o_data <= '0;
        end else if (emit) begin
            o_data <= mem[rd_addr];
        end
    end

    // Load/stream sequencer with registered status outputs
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state        <= S_LOAD;
            ld_row       <= '0;
            ld_col       <= '0;
            rd_row       <= '0;
            rd_col       <= '0;
            intr_q       <= 1'b0;
            o_ld_done    <= 1'b0;
            o_data_valid <= 1'b0;
            o_row_idx    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
`ifdef STREAM_INTR_QUEUE_EN
            pending      <= '0;
`endif
        end else begin
            intr_q       <= i_intr;
            o_done       <= 1'b0;
            o_data_valid <= emit;
            if (emit) begin
                if (rd_col == 5'd0) begin
                    o_row_idx <= rd_row;
                end
                if (rd_col == 5'(IMG_W - 1)) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 5'd1;
                end else begin
                    rd_col <= rd_col + 5'd1;
                end
            end
            if (wr_en) begin
                if (ld_col == 5'(IMG_W - 1)) begin
                    ld_col <= '0;
                    ld_row <= ld_row + 5'd1;
                end else begin
                    ld_col <= ld_col + 5'd1;
                end
            end
            case (state)
                S_LOAD: begin
                    if (wr_en && ld_last) begin
                        o_ld_done <= 1'b1;
                        ld_row    <= '0;
                        ld_col    <= '0;
                        state     <= S_READY;
`ifdef STREAM_INTR_QUEUE_EN
                        pending   <= '0;
`endif
                    end
                end
                S_READY: begin
                    if (i_ld_valid) begin
                        o_ld_done <= 1'b0;
                        state     <= S_LOAD;
                    end else if (i_start) begin
                        o_busy <= 1'b1;
                        state  <= S_PRIME;
                    end
                end
                S_PRIME: begin
`ifdef STREAM_INTR_QUEUE_EN
                    if (intr_edge && pending != 5'(IMG_H)) begin
                        pending <= pending + 5'd1;
                    end
`endif
                    if (!emit) begin
                        state <= S_WAIT_INTR;
                    end
                end
                S_WAIT_INTR: begin
`ifdef STREAM_INTR_QUEUE_EN
                    if (emit && pending != 5'd0 && !intr_edge) begin
                        pending <= pending - 5'd1;
                    end
`endif
                    if (emit) begin
                        state <= S_ROW;
                    end
                end
                S_ROW: begin
`ifdef STREAM_INTR_QUEUE_EN
                    if (intr_edge && pending != 5'(IMG_H)) begin
                        pending <= pending + 5'd1;
                    end
`endif
                    if (!emit) begin
                        if (rd_row == 5'(IMG_H)) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            rd_row <= '0;
                            state  <= S_READY;
`ifdef STREAM_INTR_QUEUE_EN
                            pending <= '0;
`endif
                        end else begin
                            state <= S_WAIT_INTR;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_img_row_streamer.sv
// tb/tb_img_row_streamer.sv - scoreboard bench for img_row_streamer
module tb_img_row_streamer;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NPIX = W * H;

    logic       axi_clk    = 1'b0;
    logic       axi_rst_n  = 1'b0;
    logic       i_ld_valid = 1'b0;
    logic [7:0] i_ld_data  = 8'd0;
    logic       i_start    = 1'b0;
    logic       i_intr     = 1'b0;
    logic       o_ld_done;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic [4:0] o_row_idx;
    logic       o_busy;
    logic       o_done;

    int total  = 0;
    int bad    = 0;
    int nbeats = 0;
    int ndone  = 0;
    int len;
    int sb[$];

    img_row_streamer dut (
        .axi_clk      (axi_clk),
        .axi_rst_n    (axi_rst_n),
        .i_ld_valid   (i_ld_valid),
        .i_ld_data    (i_ld_data),
        .o_ld_done    (o_ld_done),
        .i_start      (i_start),
        .i_intr       (i_intr),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_row_idx    (o_row_idx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 axi_clk = ~axi_clk;

    function automatic int pix(input int pat, input int k);
        return (pat != 0) ? ((k * 7 + 3) % 256) : (k % 256);
    endfunction

    // output row s is loaded row H-1-s (bottom-up load order)
    function automatic int exp_beat(input int pat, input int s, input int c);
        return s * 256 + pix(pat, (H - 1 - s) * W + c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        int e;
        @(posedge axi_clk);
        #1;
        if (o_data_valid === 1'b1) begin
            nbeats++;
            if (sb.size() == 0) begin
                chk("extra_beat", {19'd0, o_row_idx, o_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("beat", {19'd0, o_row_idx, o_data}, e);
            end
        end
        if (o_done === 1'b1) ndone++;
    endtask

    task automatic push_rows(input int pat, input int first, input int n);
        for (int s = first; s < first + n; s++)
            for (int c = 0; c < W; c++)
                sb.push_back(exp_beat(pat, s, c));
    endtask

    task automatic load_image(input int pat);
        for (int k = 0; k < NPIX; k++) begin
            i_ld_valid = 1'b1;
            i_ld_data  = 8'(pix(pat, k));
            i_start    = (k == 400);
            tick();
            if (k == NPIX - 2) chk("ld_done_early", {31'd0, o_ld_done}, 0);
        end
        i_ld_valid = 1'b0;
        i_start    = 1'b0;
        chk("ld_done", {31'd0, o_ld_done}, 1);
    endtask

    // assert start or intr, then count the valid run that follows
    task automatic kick(input bit use_intr, input int hold, input int extra_at, output int n);
        bit drv;
        n = 0;
        if (use_intr) i_intr = 1'b1; else i_start = 1'b1;
        tick();
        chk("kick_rise", {31'd0, o_data_valid}, 1);
        if (o_data_valid === 1'b1) n = 1;
        for (int i = 1; i < 600; i++) begin
            drv = (i < hold) || (i >= extra_at && i < extra_at + 3);
            if (use_intr) i_intr = drv; else i_start = drv;
            if (o_data_valid !== 1'b1 && i >= hold && i >= extra_at + 3) break;
            tick();
            if (o_data_valid === 1'b1) n++;
        end
        i_intr  = 1'b0;
        i_start = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", {31'd0, o_data_valid}, 0);
        chk("rst_data", {24'd0, o_data}, 0);
        chk("rst_ld_done", {31'd0, o_ld_done}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);
        chk("rst_done", {31'd0, o_done}, 0);
        chk("rst_row_idx", {27'd0, o_row_idx}, 0);
        axi_rst_n = 1'b1;
        tick();

        load_image(0);
        chk("load_no_beats", nbeats, 0);

        nbeats = 0;
        push_rows(0, 0, 4);
        kick(1'b0, 1, -10, len);
        chk("prime_len", len, 112);
        chk("prime_row_idx", {27'd0, o_row_idx}, 3);
        chk("prime_busy", {31'd0, o_busy}, 1);
        chk("prime_sb_empty", sb.size(), 0);

        for (int r = 4; r < H; r++) begin
            push_rows(0, r, 1);
            kick(1'b1, 3, -10, len);
            chk("row_len", len, 28);
            repeat (40) tick();
        end
        chk("total_beats", nbeats, NPIX);
        chk("done_pulses", ndone, 1);
        chk("end_busy", {31'd0, o_busy}, 0);
        chk("end_sb_empty", sb.size(), 0);

        push_rows(0, 0, 4);
        kick(1'b0, 1, -10, len);
        chk("restream_len", len, 112);
        push_rows(0, 4, 1);
        kick(1'b1, 100, -10, len);
        chk("held_intr_len", len, 28);
        repeat (10) tick();
        push_rows(0, 5, 1);
`ifdef STREAM_INTR_QUEUE_EN
        push_rows(0, 6, 1);
`endif
        kick(1'b1, 3, 10, len);
        chk("extra_pulse_len", len, 28);
        repeat (40) tick();
        chk("extra_pulse_sb_empty", sb.size(), 0);
        chk("restream_no_done", ndone, 1);

        axi_rst_n = 1'b0;
        tick();
        axi_rst_n = 1'b1;
        tick();
        load_image(1);
        nbeats = 0;
        push_rows(1, 0, 4);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (49) tick();
        chk("pre_rst_beats", nbeats, 50);
        #2;
        axi_rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, o_data_valid}, 0);
        chk("midrst_busy", {31'd0, o_busy}, 0);
        chk("midrst_data", {24'd0, o_data}, 0);
        sb.delete();
        tick();
        axi_rst_n = 1'b1;
        tick();
        chk("post_rst_ld_done", {31'd0, o_ld_done}, 0);
        nbeats = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (20) tick();
        chk("post_rst_no_beats", nbeats, 0);

        load_image(1);
        push_rows(1, 0, 4);
        kick(1'b0, 1, -10, len);
        chk("reload_prime_len", len, 112);
        chk("reload_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_row_streamer.md
Name: img_row_streamer

Overview:
- Hardware pixel source for the cnn layer-1 input port: buffers one 28x28 8-bit grayscale image and streams it row by row on the same valid/data interface the cnn consumes.
- Streams PRIME_ROWS rows back to back, then one row per rising edge of the cnn's o_intr, until all rows are sent.
- Sits between the image loader (host/DMA byte stream, BMP pixel order, bottom row first) and cnn.i_data_valid/i_data.

Parameters:
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per image
- PRIME_ROWS, 4, rows streamed after start without waiting for an interrupt
- DW, 8, pixel width
- FLIP_ROWS, 1, 1 = loaded row r is stored as row IMG_H-1-r (BMP bottom-up); 0 = no flip

Ports:
- axi_clk  in  1  clock
- axi_rst_n  in  1  asynchronous active-low reset
- i_ld_valid  in  1  load beat valid
- i_ld_data  in  DW  load pixel
- o_ld_done  out  1  image fully loaded; held until next load begins or reset
- i_start  in  1  begin streaming; sampled in READY only
- i_intr  in  1  cnn row-consumed interrupt (level; rising edge detected internally)
- o_data_valid  out  1  to cnn i_data_valid
- o_data  out  DW  to cnn i_data
- o_row_idx  out  5  output row currently or last streamed (0..IMG_H-1)
- o_busy  out  1  high in PRIME, WAIT_INTR, ROW
- o_done  out  1  one-cycle pulse after last beat of row IMG_H-1

Behaviour:
- Reset (async, axi_rst_n=0): state LOAD, all counters 0, pixel RAM contents undefined, all outputs 0, intr edge register 0.
- Storage: IMG_W*IMG_H x DW array. Write address = (FLIP_ROWS ? IMG_H-1-r : r)*IMG_W + c, with r/c the load row/column counters.
- LOAD: each i_ld_valid beat writes one pixel; c wraps at IMG_W-1 and r increments. After beat IMG_W*IMG_H, next cycle: o_ld_done=1, state READY, counters cleared. i_start is ignored in LOAD.
- READY: i_ld_valid=1 clears o_ld_done, writes beat 0 and enters LOAD. i_start=1 (without i_ld_valid) -> PRIME. If both are high, load wins.
- PRIME: o_data_valid=1 for exactly PRIME_ROWS*IMG_W consecutive cycles, starting the cycle after i_start is sampled. Pixels are read in order row 0..PRIME_ROWS-1, col 0..IMG_W-1. o_data is registered and aligned with o_data_valid. Then o_data_valid=0 and state WAIT_INTR.
- WAIT_INTR: intr edge = i_intr & ~i_intr_q. Edge sampled at cycle t -> o_data_valid=1 from t+1 for exactly IMG_W cycles (next row), state ROW. i_intr held high yields one edge only.
- ROW: after the last beat, o_data_valid=0 for at least 1 cycle. Then:
  - if the row was IMG_H-1: o_done pulses, state READY. Image is retained, so i_start restreams it.
  - otherwise: WAIT_INTR.
- o_row_idx updates on the first beat of each row.
- Intr edges arriving in PRIME/ROW/READY/LOAD are dropped (see optional feature).
- i_ld_valid outside LOAD/READY is ignored; the image buffer is never written while streaming.
- o_data holds its last value when o_data_valid=0.
- Reset mid-stream: outputs 0 immediately (async), state LOAD, o_ld_done=0. The image must be reloaded.

Optional Feature:
- Macro STREAM_INTR_QUEUE_EN.
- Defined: a 5-bit pending counter increments on each intr edge seen in PRIME or ROW (saturating at IMG_H). In WAIT_INTR, pending>0 starts the next row without a new edge and decrements the counter. The counter clears on reset and on entry to READY.
- Undefined: such edges are dropped; behaviour exactly as above.

Test Plan:
- Load ramp pixel k = k mod 256 (k=0..783), FLIP_ROWS=1 -> o_ld_done=1 one cycle after beat 783.
- Then pulse i_start -> 112 consecutive valid beats. First beat is 244, beats 11/12 are 255/0, beat 28 is 216 (stored row 1 = loaded row 26). Then valid low, o_row_idx=3.
- In WAIT_INTR, 24 i_intr pulses (3 cycles high, gaps of 40 cycles) -> each yields exactly 28 beats starting the cycle after the edge. Total 784 beats. o_done pulses once after the last beat; state READY; o_busy=0.
- i_intr held high for 100 cycles in WAIT_INTR -> exactly 28 beats. An extra pulse during ROW -> dropped (no extra row). With STREAM_INTR_QUEUE_EN, the next row starts without a new pulse.
- i_start during LOAD (beat 400) -> no valid beats. A second i_start after o_done -> identical 112-beat prime sequence.
- Deassert axi_rst_n at beat 50 of PRIME -> o_data_valid=0 and o_busy=0 immediately. After release, o_ld_done=0 and i_start is ignored until a full reload.
